// File: rtl/sine_cos_dds.sv
// Quadrature DDS: phase accumulator feeding a 3-stage quarter-wave sine/cos LUT pipeline.
// Define SINE_COS_DDS_DITHER_EN to add LFSR phase dither ahead of truncation.
module sine_cos_dds #(
  parameter int WIDTH   = 8,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter logic [PHASE_W-1:0] FCW_INIT = PHASE_W'(16'h0400)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      freq_we,
  input  logic [PHASE_W-1:0]        freq_in,
  input  logic [PHASE_W-1:0]        phase_off,
  input  logic                      sync,
  output logic signed [WIDTH-1:0]   sine,
  output logic signed [WIDTH-1:0]   cos,
  output logic                      valid
);

  localparam int N  = 1 << LUT_AW;
  localparam int PW = LUT_AW + 2;
  localparam int A  = (1 << (WIDTH - 1)) - 1;
  localparam logic [LUT_AW:0] NV = {1'b1, {LUT_AW{1'b0}}};

  // Quarter-wave table entry, evaluated only at elaboration time.
  function automatic logic [WIDTH-1:0] lut_entry(int j);
    real x;
    x = real'(A) * $sin(3.14159265358979323846 / 2.0 * real'(j) / real'(N));
    return WIDTH'($rtoi(x + 0.5));
  endfunction

  logic [WIDTH-1:0] lut [0:N];

  for (genvar j = 0; j <= N; j++) begin : g_lut
    assign lut[j] = lut_entry(j);
  end

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] fcw;
  logic [PHASE_W-1:0] p;
  logic [PW-1:0]      ph;

`ifdef SINE_COS_DDS_DITHER_EN
  localparam int DW = PHASE_W - PW;
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lfsr <= 16'hACE1;
    else if (en)
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  end

  assign p = acc + phase_off + PHASE_W'(lfsr[DW-1:0]);
`else
  assign p = acc + phase_off;
`endif

  assign ph = p[PHASE_W-1 -: PW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fcw <= FCW_INIT;
    else if (freq_we)
      fcw <= freq_in;
  end

  // sync wins over en; the increment uses the fcw held before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      acc <= '0;
    else if (sync)
      acc <= '0;
    else if (en)
      acc <= acc + fcw;
  end

  logic [1:0]        s1_qs, s1_qc;
  logic [LUT_AW-1:0] s1_i;
  logic              v1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_qs <= '0;
      s1_qc <= '0;
      s1_i  <= '0;
      v1    <= 1'b0;
    end else begin
      s1_qs <= ph[PW-1 -: 2];
      s1_qc <= ph[PW-1 -: 2] + 2'd1;
      s1_i  <= ph[LUT_AW-1:0];
      v1    <= en;
    end
  end

  // Odd quadrants read the table mirrored about the quarter point.
  logic [LUT_AW:0] addr_s, addr_c;

  always_comb begin
    addr_s = {1'b0, s1_i};
    addr_c = {1'b0, s1_i};
    if (s1_qs[0])
      addr_s = NV - {1'b0, s1_i};
    if (s1_qc[0])
      addr_c = NV - {1'b0, s1_i};
  end

  logic [WIDTH-1:0] s2_mag_s, s2_mag_c;
  logic             s2_neg_s, s2_neg_c;
  logic             v2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_mag_s <= '0;
      s2_mag_c <= '0;
      s2_neg_s <= 1'b0;
      s2_neg_c <= 1'b0;
      v2       <= 1'b0;
    end else begin
      s2_mag_s <= lut[addr_s];
      s2_mag_c <= lut[addr_c];
      s2_neg_s <= s1_qs[1];
      s2_neg_c <= s1_qc[1];
      v2       <= v1;
    end
  end

  // Outputs only change on a valid sample and otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sine  <= '0;
      cos   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= v2;
      if (v2) begin
        sine <= s2_neg_s ? -s2_mag_s : s2_mag_s;
        cos  <= s2_neg_c ? -s2_mag_c : s2_mag_c;
      end
    end
  end

endmodule

// File: tb/tb_sine_cos_dds.sv
// Self-checking bench for sine_cos_dds: trigonometric reference model plus directed vectors.
module tb_sine_cos_dds;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b0;
  logic               freq_we = 1'b0;
  logic [15:0]        freq_in = '0;
  logic [15:0]        phase_off = '0;
  logic               sync = 1'b0;
  logic signed [7:0]  sine;
  logic signed [7:0]  cos;
  logic               valid;

  sine_cos_dds dut (
    .clk(clk), .reset(reset), .en(en), .freq_we(freq_we), .freq_in(freq_in),
    .phase_off(phase_off), .sync(sync), .sine(sine), .cos(cos), .valid(valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit checking_on = 1'b0;

  localparam real PI = 3.14159265358979323846;

  typedef struct { int due; int s; int c; } samp_t;
  samp_t q[$];
  int cyc = 0;
  int macc = 0;
  int mfcw = 16'h0400;
  int mph;
  int last_s = 0;
  int last_c = 0;

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Expected sample for an 8-bit truncated phase, straight from the trig definition.
  function automatic int model_sin(int ph8);
    return rnd(127.0 * $sin(2.0 * PI * real'(ph8) / 256.0));
  endfunction

  function automatic int model_cos(int ph8);
    return rnd(127.0 * $cos(2.0 * PI * real'(ph8) / 256.0));
  endfunction

  function automatic void checkEq(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      macc   = 0;
      mfcw   = 16'h0400;
      last_s = 0;
      last_c = 0;
    end else begin
      cyc++;
      if (en) begin
        mph = ((macc + int'(phase_off)) & 16'hFFFF) >> 8;
        q.push_back('{cyc + 2, model_sin(mph), model_cos(mph)});
      end
      if (sync)
        macc = 0;
      else if (en)
        macc = (macc + mfcw) & 16'hFFFF;
      if (freq_we)
        mfcw = int'(freq_in);
    end
  end

  // Every cycle: valid must match the model, outputs must match the latest expected sample.
  always @(negedge clk) begin
    if (checking_on) begin
      bit exp_valid;
      while (q.size() > 0 && q[0].due < cyc)
        void'(q.pop_front());
      exp_valid = reset && q.size() > 0 && q[0].due == cyc;
      checkEq("cycle_valid", int'(valid), exp_valid ? 1 : 0);
      if (exp_valid) begin
        last_s = q[0].s;
        last_c = q[0].c;
        void'(q.pop_front());
      end
      checkEq("cycle_sine", int'(sine), last_s);
      checkEq("cycle_cos", int'(cos), last_c);
    end
  end

  task automatic applyStimulus(input bit e, input bit s, input bit fw,
                               input logic [15:0] fi, input logic [15:0] po);
    en        = e;
    sync      = s;
    freq_we   = fw;
    freq_in   = fi;
    phase_off = po;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int es, input int ec);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < 12);
    if (valid !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: valid got 0, expected 1 within 12 cycles", name);
    end else begin
      checkEq({name, "_sine"}, int'(sine), es);
      checkEq({name, "_cos"}, int'(cos), ec);
    end
  endtask

  initial begin
    checkEq("model_sin_8", model_sin(8), 25);
    checkEq("model_sin_32", model_sin(32), 90);
    checkEq("model_sin_200", model_sin(200), -125);
    checkEq("model_cos_4", model_cos(4), 126);

    #1 reset = 1'b0;
    checking_on = 1'b1;
    cycles(3);
    reset = 1'b1;
    cycles(6);
    checkEq("idle_valid", int'(valid), 0);
    checkEq("idle_sine", int'(sine), 0);
    checkEq("idle_cos", int'(cos), 0);

    applyStimulus(0, 0, 1, 16'h4000, 16'h0000);
    cycles(1);
    applyStimulus(0, 1, 0, 16'h0000, 16'h0000);
    cycles(1);
    applyStimulus(1, 0, 0, 16'h0000, 16'h0000);
    checkOutput("quarter0", 0, 127);
    checkOutput("quarter1", 127, 0);
    checkOutput("quarter2", 0, -127);
    checkOutput("quarter3", -127, 0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    cycles(4);

    applyStimulus(0, 1, 0, 16'h0000, 16'h4000);
    cycles(1);
    applyStimulus(1, 0, 0, 16'h0000, 16'h4000);
    checkOutput("offset", 127, 0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    cycles(4);

    applyStimulus(0, 0, 1, 16'hC000, 16'h0000);
    cycles(1);
    applyStimulus(0, 1, 0, 16'h0000, 16'h0000);
    cycles(1);
    applyStimulus(1, 0, 0, 16'h0000, 16'h0000);
    checkOutput("wrap0", 0, 127);
    checkOutput("wrap1", -127, 0);
    checkOutput("wrap2", 0, -127);
    checkOutput("wrap3", 127, 0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    cycles(4);

    applyStimulus(0, 0, 1, 16'h4000, 16'h0000);
    cycles(1);
    applyStimulus(0, 1, 0, 16'h0000, 16'h0000);
    cycles(1);
    applyStimulus(1, 0, 0, 16'h0000, 16'h0000);
    cycles(1);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    cycles(1);
    applyStimulus(1, 0, 0, 16'h0000, 16'h0000);
    checkOutput("gap_first", 0, 127);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("gap_second", 127, 0);
    cycles(4);

    applyStimulus(0, 1, 0, 16'h0000, 16'h0000);
    cycles(1);
    applyStimulus(1, 0, 0, 16'h0000, 16'h0000);
    checkOutput("prerst0", 0, 127);
    checkOutput("prerst1", 127, 0);
    #2 reset = 1'b0;
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    #1;
    checkEq("rst_valid", int'(valid), 0);
    checkEq("rst_sine", int'(sine), 0);
    checkEq("rst_cos", int'(cos), 0);
    cycles(2);
    reset = 1'b1;
    applyStimulus(1, 0, 0, 16'h0000, 16'h0000);
    checkOutput("postrst0", 0, 127);
    checkOutput("postrst1", 12, 126);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    cycles(5);

    checking_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
